// File: rtl/panel_pwm_sequencer.sv
// panel_pwm_sequencer
// Timing generator for one cube panel's LED data path. Every PWM slot is a
// LED sub-slot (load, SHIFT_LEN serial clocks, latch). Slot 0 of each frame is
// preceded by a brightness sub-slot. Outputs drive the component drivers'
// strobes and the panel's serial clock, latch, mode-select and blank pins.
//
// Ports:
//   clk             - system clock, rising edge
//   reset_n         - asynchronous active-low reset
//   enable          - level-sensitive run request
//   pwm_time        - current PWM slot (0..255)
//   load_led_vals   - one-cycle strobe, parallel-load LED comparator results
//   load_brightness - one-cycle strobe, parallel-load brightness word
//   shift           - one-cycle strobe, advance shift registers one bit
//   serial_clk      - panel serial clock (data sampled on its rising edge)
//   latch           - panel latch pulse, LATCH_WIDTH cycles
//   mode_sel        - 1 during a brightness sub-slot, 0 otherwise
//   blank           - panel output blank, active high
//   frame_start     - one-cycle pulse in the cycle pwm_time wraps 255 -> 0

module panel_pwm_sequencer #(
    parameter int unsigned SHIFT_LEN   = 16,
    parameter int unsigned LATCH_WIDTH = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       enable,
    output logic [7:0] pwm_time,
    output logic       load_led_vals,
    output logic       load_brightness,
    output logic       shift,
    output logic       serial_clk,
    output logic       latch,
    output logic       mode_sel,
    output logic       blank,
    output logic       frame_start
);

    localparam int unsigned BitW   = $clog2(SHIFT_LEN + 1);
    localparam int unsigned LatchW = $clog2(LATCH_WIDTH + 1);

    localparam logic [BitW-1:0]   LastBit   = BitW'(SHIFT_LEN - 1);
    localparam logic [LatchW-1:0] LastLatch = LatchW'(LATCH_WIDTH - 1);

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StClkHi,
        StClkLo,
        StLatch
    } state_e;

    state_e              state_q;
    logic                phase_bri_q;
    logic [BitW-1:0]     bit_cnt_q;
    logic [LatchW-1:0]   latch_cnt_q;
    logic [7:0]          pwm_time_q;
    logic                load_led_vals_q;
    logic                load_brightness_q;
    logic                shift_q;
    logic                serial_clk_q;
    logic                latch_q;
    logic                mode_sel_q;
    logic                blank_q;
    logic                frame_start_q;

    // Outputs are registered against the state being entered, so each strobe
    // is high in exactly the cycle its state is occupied.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q           <= StIdle;
            phase_bri_q       <= 1'b0;
            bit_cnt_q         <= '0;
            latch_cnt_q       <= '0;
            pwm_time_q        <= 8'd0;
            load_led_vals_q   <= 1'b0;
            load_brightness_q <= 1'b0;
            shift_q           <= 1'b0;
            serial_clk_q      <= 1'b0;
            latch_q           <= 1'b0;
            mode_sel_q        <= 1'b0;
            blank_q           <= 1'b1;
            frame_start_q     <= 1'b0;
        end else begin
            load_led_vals_q   <= 1'b0;
            load_brightness_q <= 1'b0;
            shift_q           <= 1'b0;
            serial_clk_q      <= 1'b0;
            latch_q           <= 1'b0;
            frame_start_q     <= 1'b0;

            case (state_q)
                StIdle: begin
                    phase_bri_q <= (pwm_time_q == 8'd0);
                    if (enable) begin
                        state_q           <= StLoad;
                        bit_cnt_q         <= '0;
                        load_brightness_q <= (pwm_time_q == 8'd0);
                        load_led_vals_q   <= (pwm_time_q != 8'd0);
                        mode_sel_q        <= (pwm_time_q == 8'd0);
                    end
                end

                StLoad: begin
                    state_q      <= StClkHi;
                    serial_clk_q <= 1'b1;
                end

                StClkHi: begin
                    state_q <= StClkLo;
                    shift_q <= 1'b1;
                end

                StClkLo: begin
                    if (bit_cnt_q == LastBit) begin
                        state_q     <= StLatch;
                        latch_cnt_q <= '0;
                        latch_q     <= 1'b1;
                    end else begin
                        bit_cnt_q    <= bit_cnt_q + BitW'(1);
                        state_q      <= StClkHi;
                        serial_clk_q <= 1'b1;
                    end
                end

                StLatch: begin
                    if (latch_cnt_q != LastLatch) begin
                        latch_cnt_q <= latch_cnt_q + LatchW'(1);
                        latch_q     <= 1'b1;
                    end else if (phase_bri_q) begin
                        // Brightness word latched; the LED sub-slot of the same
                        // slot always follows, regardless of enable.
                        phase_bri_q     <= 1'b0;
                        state_q         <= StLoad;
                        bit_cnt_q       <= '0;
                        load_led_vals_q <= 1'b1;
                        mode_sel_q      <= 1'b0;
                    end else begin
                        pwm_time_q    <= pwm_time_q + 8'd1;
                        frame_start_q <= (pwm_time_q == 8'd255);
                        if (enable) begin
                            state_q           <= StLoad;
                            bit_cnt_q         <= '0;
                            blank_q           <= 1'b0;
                            phase_bri_q       <= (pwm_time_q == 8'd255);
                            load_brightness_q <= (pwm_time_q == 8'd255);
                            load_led_vals_q   <= (pwm_time_q != 8'd255);
                            mode_sel_q        <= (pwm_time_q == 8'd255);
                        end else begin
                            state_q    <= StIdle;
                            blank_q    <= 1'b1;
                            mode_sel_q <= 1'b0;
                        end
                    end
                end

                default: begin
                    state_q    <= StIdle;
                    blank_q    <= 1'b1;
                    mode_sel_q <= 1'b0;
                end
            endcase
        end
    end

    assign pwm_time        = pwm_time_q;
    assign load_led_vals   = load_led_vals_q;
    assign load_brightness = load_brightness_q;
    assign shift           = shift_q;
    assign serial_clk      = serial_clk_q;
    assign latch           = latch_q;
    assign mode_sel        = mode_sel_q;
    assign blank           = blank_q;
    assign frame_start     = frame_start_q;

endmodule

// File: tb/tb_panel_pwm_sequencer.sv
// Bench for panel_pwm_sequencer: a default instance and a SHIFT_LEN=4 /
// LATCH_WIDTH=1 instance share clock, reset and enable. A slot-position model
// predicts every output each cycle; literal checks pin the model to the
// expected waveforms of the first slot, enable drop, wrap and async reset.

module tb_panel_pwm_sequencer;

    localparam int L0 = 16;
    localparam int W0 = 2;
    localparam int L1 = 4;
    localparam int W1 = 1;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic enable = 1'b0;

    always #5 clk = ~clk;

    logic [7:0] pwm0, pwm1;
    logic ll0, lb0, sh0, sck0, lat0, ms0, bl0, fs0;
    logic ll1, lb1, sh1, sck1, lat1, ms1, bl1, fs1;

    panel_pwm_sequencer #(.SHIFT_LEN(L0), .LATCH_WIDTH(W0)) u_dut0 (
        .clk(clk), .reset_n(reset_n), .enable(enable), .pwm_time(pwm0),
        .load_led_vals(ll0), .load_brightness(lb0), .shift(sh0), .serial_clk(sck0),
        .latch(lat0), .mode_sel(ms0), .blank(bl0), .frame_start(fs0)
    );

    panel_pwm_sequencer #(.SHIFT_LEN(L1), .LATCH_WIDTH(W1)) u_dut1 (
        .clk(clk), .reset_n(reset_n), .enable(enable), .pwm_time(pwm1),
        .load_led_vals(ll1), .load_brightness(lb1), .shift(sh1), .serial_clk(sck1),
        .latch(lat1), .mode_sel(ms1), .blank(bl1), .frame_start(fs1)
    );

    // Packed view: [15:8] pwm, [7] ll, [6] lb, [5] shift, [4] sclk, [3] latch,
    // [2] mode_sel, [1] blank, [0] frame_start.
    logic [15:0] act [2];
    assign act[0] = {pwm0, ll0, lb0, sh0, sck0, lat0, ms0, bl0, fs0};
    assign act[1] = {pwm1, ll1, lb1, sh1, sck1, lat1, ms1, bl1, fs1};

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s at t=%0t: got 0x%0h, expected 0x%0h", name, $time, got, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    int m_len [2] = '{L0, L1};
    int m_lw  [2] = '{W0, W1};
    bit m_run [2];
    bit m_bri [2];
    int m_pos [2];
    int m_pwm [2];
    bit m_blank [2] = '{1'b1, 1'b1};
    bit m_fs  [2];

    task automatic model_reset(input int i);
        m_run[i] = 0; m_bri[i] = 0; m_pos[i] = 0; m_pwm[i] = 0;
        m_blank[i] = 1; m_fs[i] = 0;
    endtask

    task automatic model_step(input int i, input bit en);
        int s;
        s = 1 + 2 * m_len[i] + m_lw[i];
        m_fs[i] = 0;
        if (!m_run[i]) begin
            if (en) begin
                m_run[i] = 1; m_pos[i] = 0; m_bri[i] = (m_pwm[i] == 0);
            end
        end else if (m_pos[i] == s - 1) begin
            if (m_bri[i]) begin
                m_bri[i] = 0; m_pos[i] = 0;
            end else begin
                m_fs[i]  = (m_pwm[i] == 255);
                m_pwm[i] = (m_pwm[i] + 1) % 256;
                if (en) begin
                    m_pos[i] = 0; m_bri[i] = (m_pwm[i] == 0); m_blank[i] = 0;
                end else begin
                    m_run[i] = 0; m_blank[i] = 1;
                end
            end
        end else begin
            m_pos[i]++;
        end
    endtask

    function automatic logic [15:0] model_out(input int i);
        logic ld, sc, sh, la, ms;
        int p, l2;
        p  = m_pos[i];
        l2 = 2 * m_len[i];
        ld = m_run[i] && (p == 0);
        sc = m_run[i] && (p % 2 == 1) && (p < l2);
        sh = m_run[i] && (p % 2 == 0) && (p >= 2) && (p <= l2);
        la = m_run[i] && (p > l2);
        ms = m_run[i] && m_bri[i];
        return {8'(m_pwm[i]), ld && !m_bri[i], ld && m_bri[i], sh, sc, la, ms,
                m_blank[i], m_fs[i]};
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 2; i++) model_reset(i);
        end else begin
            for (int i = 0; i < 2; i++) model_step(i, enable);
        end
    end

    bit cmp_en = 0;
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("inst0 outputs", int'(act[0]), int'(model_out(0)));
            chk("inst1 outputs", int'(act[1]), int'(model_out(1)));
        end
    end

    // Frame-length monitor, active only while enable is held high.
    bit wrap_phase = 0;
    int cyc = 0;
    int last_fs [2] = '{-1, -1};
    int n_frames [2] = '{0, 0};
    always @(negedge clk) begin
        cyc++;
        if (!wrap_phase) begin
            last_fs[0] = -1; last_fs[1] = -1;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (act[i][0]) begin
                    if (last_fs[i] >= 0) begin
                        chk(i == 0 ? "frame length inst0" : "frame length inst1",
                            cyc - last_fs[i], (i == 0) ? 8995 : 2570);
                        n_frames[i]++;
                    end
                    last_fs[i] = cyc;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    logic [15:0] rec0 [71];
    logic [15:0] rec1 [71];

    initial begin
        int cnt, cnt_ok;
        bit found;

        reset_n = 1'b0;
        enable  = 1'b0;
        repeat (2) @(posedge clk);
        cmp_en = 1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("reset values inst0", int'(act[0]), 16'h0002);
            chk("reset values inst1", int'(act[1]), 16'h0002);
            enable = 1'($urandom_range(0, 1));
        end

        // First slot from pwm_time=0
        @(negedge clk);
        reset_n = 1'b1;
        enable  = 1'b1;
        for (int c = 0; c <= 70; c++) begin
            @(negedge clk);
            rec0[c] = act[0];
            rec1[c] = act[1];
        end
        chk("bri load cycle0", int'(rec0[0][6]), 1);
        cnt = 0;
        for (int c = 0; c <= 34; c++) cnt += int'(rec0[c][2]);
        chk("mode_sel cycles 0-34", cnt, 35);
        cnt = 0; cnt_ok = 0;
        for (int c = 0; c <= 34; c++) begin
            cnt += int'(rec0[c][5]);
            if (c % 2 == 0 && c >= 2 && c <= 32) cnt_ok += int'(rec0[c][5]);
        end
        chk("bri shift count", cnt, 16);
        chk("bri shifts at even 2-32", cnt_ok, 16);
        cnt = 0;
        for (int c = 0; c <= 34; c++) cnt += int'(rec0[c][3]);
        chk("bri latch count", cnt, 2);
        chk("bri latch cycle33", int'(rec0[33][3]), 1);
        chk("bri latch cycle34", int'(rec0[34][3]), 1);
        chk("led load cycle35", int'(rec0[35][7]), 1);
        chk("led mode_sel cycle35", int'(rec0[35][2]), 0);
        chk("pwm held cycle69", int'(rec0[69][15:8]), 0);
        chk("pwm cycle70", int'(rec0[70][15:8]), 1);
        chk("blank cycle70", int'(rec0[70][1]), 0);
        cnt = 0; cnt_ok = 0;
        for (int c = 0; c <= 9; c++) begin
            cnt += int'(rec1[c][5]);
            cnt_ok += int'(rec1[c][3]);
        end
        chk("inst1 shift count", cnt, 4);
        chk("inst1 latch count", cnt_ok, 1);
        chk("inst1 led load cycle10", int'(rec1[10][7]), 1);
        chk("inst1 pwm cycle20", int'(rec1[20][15:8]), 1);

        // Enable drop during bit 5 of LED sub-slot at pwm_time=7
        found = 0;
        for (int k = 0; k < 400 && !found; k++) begin
            @(negedge clk);
            if (act[0][7] && act[0][15:8] == 8'd7) found = 1;
        end
        chk("reach pwm 7 load", int'(found), 1);
        repeat (11) @(negedge clk);
        chk("bit5 serial_clk", int'(act[0][4]), 1);
        enable = 1'b0;
        repeat (23) @(negedge clk);
        chk("drop latch still runs", int'(act[0][3]), 1);
        chk("drop pwm during latch", int'(act[0][15:8]), 7);
        @(negedge clk);
        chk("idle pwm", int'(act[0][15:8]), 8);
        chk("idle blank", int'(act[0][1]), 1);
        chk("idle mode_sel", int'(act[0][2]), 0);
        repeat (3) @(negedge clk);
        chk("idle hold pwm", int'(act[0][15:8]), 8);
        chk("idle hold strobes", int'(act[0][7:2]), 0);
        enable = 1'b1;
        @(negedge clk);
        chk("re-enable led load", int'(act[0][7]), 1);
        chk("re-enable no bri", int'(act[0][6]), 0);
        chk("re-enable pwm", int'(act[0][15:8]), 8);

        // Continuous run across wraps
        wrap_phase = 1;
        for (int k = 0; k < 30000 && n_frames[0] < 2; k++) @(negedge clk);
        chk("inst0 frames measured", int'(n_frames[0] >= 2), 1);
        chk("inst1 frames measured", int'(n_frames[1] >= 2), 1);
        wrap_phase = 0;

        // Asynchronous reset inside a CLK_HI cycle
        found = 0;
        for (int k = 0; k < 20 && !found; k++) begin
            @(negedge clk);
            if (act[0][4]) found = 1;
        end
        chk("find serial_clk high", int'(found), 1);
        #1 reset_n = 1'b0;
        #1;
        chk("async reset inst0", int'(act[0]), 16'h0002);
        chk("async reset inst1", int'(act[1]), 16'h0002);
        repeat (2) @(negedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
        chk("restart bri load", int'(act[0][6]), 1);
        chk("restart mode_sel", int'(act[0][2]), 1);
        chk("restart pwm", int'(act[0][15:8]), 0);
        chk("restart inst1 bri load", int'(act[1][6]), 1);
        repeat (80) @(negedge clk);

        cmp_en = 0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/panel_pwm_sequencer.md
# panel_pwm_sequencer

Timing generator for one cube panel's LED data path. It sits directly upstream of the per-colour component drivers and produces their control signals: the `pwm_time` slot counter and the `load_led_vals`, `load_brightness` and `shift` strobes. It also drives the panel's serial clock, latch, mode-select and blank pins, so the LED driver chips receive one 16-bit word per PWM slot and a brightness word once per frame.

## Interface
- `SHIFT_LEN`, default 16: bits shifted per sub-slot; must equal the component driver's shift register width; minimum 1.
- `LATCH_WIDTH`, default 2: length of each latch pulse in clk cycles; minimum 1.

- `clk`, in, 1: system clock; all logic is on the rising edge.
- `reset_n`, in, 1: asynchronous, active-low reset.
- `enable`, in, 1: run request, level-sensitive.
- `pwm_time`, out, 8: current PWM slot; feeds the component-driver comparators.
- `load_led_vals`, out, 1: one-cycle strobe that parallel-loads the LED comparator results.
- `load_brightness`, out, 1: one-cycle strobe that parallel-loads the brightness word.
- `shift`, out, 1: one-cycle strobe that advances the shift registers by one bit.
- `serial_clk`, out, 1: panel serial clock; panel chips sample data on its rising edge.
- `latch`, out, 1: panel latch pulse.
- `mode_sel`, out, 1: 1 during a brightness sub-slot, 0 during an LED sub-slot.
- `blank`, out, 1: panel output blank, active high.
- `frame_start`, out, 1: one-cycle pulse when `pwm_time` wraps from 255 to 0.

## Operation
- All outputs are registered. Reset values: `pwm_time`=0, `blank`=1, every other output 0, FSM in IDLE.
- FSM states: IDLE, LOAD, CLK_HI, CLK_LO, LATCH. Internal registers: phase (BRI/LED), bit counter, latch counter.
- **IDLE:**
  - If `enable`=1, go to LOAD.
  - Phase is set to BRI when `pwm_time`=0, otherwise to LED.
- **LOAD:**
  - Drive `load_brightness` (BRI phase) or `load_led_vals` (LED phase) for 1 cycle.
  - Clear the bit counter, then go to CLK_HI.
- **CLK_HI:** `serial_clk`=1 for 1 cycle, then go to CLK_LO.
- **CLK_LO:**
  - `serial_clk`=0 and `shift`=1 for 1 cycle; increment the bit counter.
  - After the SHIFT_LEN-th CLK_LO, go to LATCH; otherwise go back to CLK_HI.
- **LATCH:** `latch`=1 for LATCH_WIDTH cycles. On exit:
  - BRI phase: set phase to LED and go to LOAD. `pwm_time` is unchanged.
  - LED phase:
    - Increment `pwm_time` modulo 256.
    - If this increment wraps 255 to 0, `frame_start`=1 in the next cycle.
    - Clear `blank` (it stays 0 while running).
    - Go to LOAD if `enable`=1, otherwise go to IDLE.
    - On the LOAD path, phase is BRI if the new `pwm_time`=0, otherwise LED.
- `mode_sel` equals phase==BRI for every cycle from LOAD through LATCH; it is 0 in IDLE.
- Entering IDLE sets `blank`=1.
- Dropping `enable` mid-slot does not abort. The current slot, including any LED sub-slot that follows a BRI sub-slot, completes through its LED latch, then the FSM enters IDLE.
- Re-enabling resumes from the held `pwm_time`. A BRI sub-slot runs only if that value is 0.
- Asserting `reset_n` low at any time immediately forces the reset values. A partial shift is discarded.

## Timing
- Slot length S = 1 + 2·SHIFT_LEN + LATCH_WIDTH. The default is S = 35 cycles.
- Cycle numbering within a sub-slot, counted from LOAD = 0:
  - Cycle 0: load strobe.
  - Cycles 1+2k: `serial_clk`=1, for bit k.
  - Cycles 2+2k: `shift`=1, for bit k.
  - Cycles 2·SHIFT_LEN+1 through S−1: `latch`=1.
- `pwm_time` changes only in the cycle after the last LED latch cycle. It is therefore stable during every load strobe.
- Frame length is 256·S + S. At defaults this is 8995 cycles, measured from one `frame_start` to the next.
- `enable` rising while in IDLE: LOAD occurs in the next cycle, i.e. a 1-cycle latency.
- There is never an idle cycle between consecutive sub-slots while `enable` stays 1.

## Test plan
- **Reset values:** hold `reset_n`=0 with random `enable` → `pwm_time`=0, `blank`=1, all strobes and `serial_clk`/`latch`/`mode_sel`/`frame_start` are 0.
- **First slot after enable at `pwm_time`=0 (defaults):**
  - Cycles 0–34 (BRI sub-slot): `mode_sel`=1; `load_brightness` at cycle 0; 16 `shift` pulses at even cycles 2–32; `latch` at cycles 33–34.
  - Cycles 35–69 (LED sub-slot): `load_led_vals` at cycle 35.
  - Cycle 70: `pwm_time`=1 and `blank`=0.
- **Wrap:** run continuously → `frame_start` pulses once per 8995 cycles, coinciding with `pwm_time` going 255→0. Each wrap is followed by exactly one BRI sub-slot.
- **Enable drop:** deassert `enable` during bit 5 of the LED sub-slot at `pwm_time`=7 → the remaining shifts and the latch complete, `pwm_time`=8, then IDLE with `blank`=1. On re-enable, `load_led_vals` occurs 1 cycle later with no BRI sub-slot.
- **Asynchronous reset mid-shift:** pulse `reset_n` low between clock edges during CLK_HI → outputs take reset values immediately. After release with `enable`=1, a BRI sub-slot restarts from cycle 0.
- **Parameters:** SHIFT_LEN=4, LATCH_WIDTH=1 → S=10. Exactly 4 `shift` pulses and 1 `latch` cycle per sub-slot; frame length is 2570 cycles.
